// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the execute-stage decoder and the iterative multiply/divide unit.
// The master drives the requests and reads the status; the slave is the unit itself.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operates on magnitudes (shift-add / restoring divide) and applies sign correction in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       is_div_q, is_div_d;
    logic                       sign_a_q, sign_a_d;
    logic                       sign_b_q, sign_b_d;
    logic                       divz_q, divz_d;
    logic [WIDTH-1:0]           a_q, a_d;
    logic [WIDTH-1:0]           b_q, b_d;
    logic [2*WIDTH-1:0]         acc_q, acc_d;
    logic [WIDTH-1:0]           hi_q, hi_d;
    logic [WIDTH-1:0]           lo_q, lo_d;
    logic                       done_q, done_d;
    logic [WIDTH:0]             mul_sum;
    logic [WIDTH:0]             div_rem;
    logic [WIDTH:0]             div_diff;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        divz_d   = divz_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        mul_sum  = '0;
        div_rem  = '0;
        div_diff = '0;

        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start && !bus.cancel) begin
                    is_div_d = bus.op[1];
                    sign_a_d = ~bus.op[0] & bus.a[WIDTH-1];
                    sign_b_d = ~bus.op[0] & bus.b[WIDTH-1];
                    divz_d   = bus.op[1] && (bus.b == '0);
                    // Divide by zero reports the raw dividend in HI, so keep it unprocessed.
                    a_d      = divz_d ? bus.a : magnitude(bus.a, ~bus.op[0]);
                    b_d      = magnitude(bus.b, ~bus.op[0]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = divz_d ? FIX : RUN;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        // acc = {partial remainder, quotient}; dividend bits enter from a_q's MSB.
                        div_rem  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
                        div_diff = div_rem - {1'b0, b_q};
                        if (!div_diff[WIDTH])
                            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        else
                            acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        a_d = {a_q[WIDTH-2:0], 1'b0};
                    end else begin
                        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
                        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
                        b_d     = {1'b0, b_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (divz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        lo_d = negate(acc_q[WIDTH-1:0], sign_a_q ^ sign_b_q);
                        hi_d = negate(acc_q[2*WIDTH-1:WIDTH], sign_a_q);
                    end else begin
                        {hi_d, lo_d} = negate_wide(acc_q, sign_a_q ^ sign_b_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            divz_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            divz_q   <= divz_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written corner sequences and a randomized
// run scored against a plain-arithmetic MIPS HI/LO model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural result of one operation, straight from the MIPS HI/LO definition.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin sp = sa * sb; {hi, lo} = sp; end
            2'b01: begin up = ua * ub; {hi, lo} = up; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
            end
        endcase
    endfunction

    // Issues one op and waits for done; returns edges from accept to done and busy-high cycles.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("done_low_after_accept", {63'd0, bus.done}, 64'd0);
        busy_cyc = bus.busy ? 1 : 0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
    endtask

    vec_t        vecs[$];
    int          lat, bcyc, n;
    logic [31:0] ehi, elo, ra, rb;
    logic [1:0]  rop;
    bit          seen_done;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        vecs.push_back('{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33});
        vecs.push_back('{"mult_m3x5",   2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33});
        vecs.push_back('{"div_m7d2",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33});
        vecs.push_back('{"divu_100d7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       33});
        vecs.push_back('{"div_minm1",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33});
        vecs.push_back('{"divu_by0",    2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1});
        vecs.push_back('{"div_by0_raw", 2'b10, 32'h80000005, 32'h00000000, 32'h80000005, 32'hFFFFFFFF, 1});
        vecs.push_back('{"mult_minsq",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33});
        vecs.push_back('{"div_7dm2",    2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33});
        vecs.push_back('{"multu_zero",  2'b01, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 33});

        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.cancel = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        chk("reset_busy", {63'd0, bus.busy}, 0);
        chk("reset_done", {63'd0, bus.done}, 0);
        resetn = 1'b1;

        // Directed table, issued back-to-back (each start lands in the previous done cycle).
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcyc);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_busy"}, bcyc, vecs[i].lat);
            chk({vecs[i].name, "_hi"}, bus.hi, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, bus.lo, vecs[i].lo);
        end

        // MTHI/MTLO in IDLE, then ignored during RUN together with a stray start.
        @(negedge clk);
        bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus.hi_we = 0; bus.lo_we = 0;
        chk("mt_idle_hi", bus.hi, 32'hA5A5A5A5);
        chk("mt_idle_lo", bus.lo, 32'hA5A5A5A5);
        @(negedge clk);
        bus.start = 1; bus.op = 2'b01; bus.a = 6; bus.b = 7;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (3) @(posedge clk);
        #1;
        bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'h12345678;
        bus.start = 1; bus.op = 2'b11; bus.a = 5; bus.b = 0;
        @(posedge clk); #1;
        bus.hi_we = 0; bus.lo_we = 0; bus.start = 0;
        chk("mt_run_hi", bus.hi, 32'hA5A5A5A5);
        chk("mt_run_lo", bus.lo, 32'hA5A5A5A5);
        chk("start_in_run_busy", {63'd0, bus.busy}, 1);
        n = 4;
        while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
        chk("run_ignore_lat", n, 33);
        chk("run_ignore_hi", bus.hi, 0);
        chk("run_ignore_lo", bus.lo, 42);

        // Direct write and start on the same IDLE edge both take effect.
        @(negedge clk);
        bus.hi_we = 1; bus.wdata = 32'hCAFEF00D;
        bus.start = 1; bus.op = 2'b11; bus.a = 32'd50; bus.b = 32'd8;
        @(posedge clk); #1;
        bus.hi_we = 0; bus.start = 0;
        chk("mt_with_start_hi", bus.hi, 32'hCAFEF00D);
        chk("mt_with_start_busy", {63'd0, bus.busy}, 1);
        n = 0;
        while (!bus.done && n < 100) begin @(posedge clk); #1; n++; end
        chk("mt_with_start_qlo", bus.lo, 6);
        chk("mt_with_start_rhi", bus.hi, 2);

        // Cancel in IDLE blocks a same-cycle start.
        @(negedge clk);
        bus.start = 1; bus.cancel = 1; bus.op = 2'b01; bus.a = 3; bus.b = 3;
        @(posedge clk); #1;
        bus.start = 0; bus.cancel = 0;
        chk("cancel_idle_busy", {63'd0, bus.busy}, 0);

        // Cancel during RUN: sampled at E11, no done, HI/LO untouched.
        @(negedge clk);
        bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'h11112222;
        bus.start = 1; bus.op = 2'b01; bus.a = 32'h10; bus.b = 32'h20;
        @(posedge clk); #1;
        bus.hi_we = 0; bus.lo_we = 0; bus.start = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("cancel_pre_busy", {63'd0, bus.busy}, 1);
        bus.cancel = 1;
        @(posedge clk); #1;
        bus.cancel = 0;
        chk("cancel_busy", {63'd0, bus.busy}, 0);
        seen_done = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done) seen_done = 1; end
        chk("cancel_no_done", {63'd0, seen_done}, 0);
        chk("cancel_hi", bus.hi, 32'h11112222);
        chk("cancel_lo", bus.lo, 32'h11112222);

        // Reset in the middle of a DIV, then a fresh op.
        @(negedge clk);
        bus.start = 1; bus.op = 2'b10; bus.a = 32'hFFFFFF9C; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (4) @(posedge clk);
        #1;
        resetn = 0;
        @(posedge clk); #1;
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        chk("midrst_busy", {63'd0, bus.busy}, 0);
        chk("midrst_done", {63'd0, bus.done}, 0);
        resetn = 1;
        seen_done = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done) seen_done = 1; end
        chk("midrst_no_done", {63'd0, seen_done}, 0);
        run_op(2'b10, 32'hFFFFFF9C, 32'd7, lat, bcyc);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_lo", bus.lo, 32'hFFFFFFF2);
        chk("post_rst_hi", bus.hi, 32'hFFFFFFFE);

        // Randomized back-to-back ops against the reference model.
        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            model(rop, ra, rb, ehi, elo);
            run_op(rop, ra, rb, lat, bcyc);
            chk("rand_lat", lat, (rop[1] && rb == 0) ? 1 : 33);
            chk("rand_hi", bus.hi, ehi);
            chk("rand_lo", bus.lo, elo);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
